// File: rtl/fb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fb_port_arbiter
// Brief   : Shares a single-port frame RAM between a non-stalling byte writer
//           (buffered in a small write FIFO) and a valid/ack panel reader.
//           Optional statistics (dropCount, maxLevel) under FB_ARB_STATS_EN.
// Revision: 1.0
// ============================================================================
module fb_port_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 8,
    parameter int WFIFO_AW = 2,
    parameter int HI_WATER = 3
) (
    input  logic                pixClk,
    input  logic                nReset,
    input  logic                frameStart,
    input  logic                wrPix,
    input  logic [ADDR_W-1:0]   wrAddr,
    input  logic [DATA_W-1:0]   wrData,
    input  logic                rdReq,
    input  logic [ADDR_W-1:0]   rdAddr,
    output logic                rdAck,
    output logic                rdValid,
    output logic [DATA_W-1:0]   rdData,
    output logic [ADDR_W-1:0]   ramAddr,
    output logic [DATA_W-1:0]   ramWrData,
    output logic                ramWe,
    output logic                ramRe,
    input  logic [DATA_W-1:0]   ramRdData,
    output logic [WFIFO_AW:0]   fifoLevel,
`ifdef FB_ARB_STATS_EN
    output logic [15:0]         dropCount,
    output logic [WFIFO_AW:0]   maxLevel,
`endif
    output logic                wrOverflow
);

    localparam int                c_DEPTH = 1 << WFIFO_AW;
    localparam logic [WFIFO_AW:0] c_FULL  = c_DEPTH[WFIFO_AW:0];
    localparam logic [WFIFO_AW:0] c_HI    = HI_WATER[WFIFO_AW:0];

    typedef enum logic [1:0] {
        GNT_IDLE  = 2'd0,
        GNT_READ  = 2'd1,
        GNT_WRITE = 2'd2
    } grant_t;

    logic [ADDR_W+DATA_W-1:0] r_mem [c_DEPTH];
    logic [WFIFO_AW-1:0]      r_wrPtr;
    logic [WFIFO_AW-1:0]      r_rdPtr;
    logic [WFIFO_AW:0]        r_level;
    logic                     r_lastWrite;
    logic                     r_ramWe;
    logic                     r_ramRe;
    logic [ADDR_W-1:0]        r_ramAddr;
    logic [DATA_W-1:0]        r_ramWrData;
    logic                     r_rdInFlight;
    logic                     r_rdValid;
    logic [DATA_W-1:0]        r_rdData;
    logic                     r_wrOverflow;

    grant_t                   w_grant;
    logic                     w_wrPend;
    logic                     w_hiWater;
    logic                     w_contended;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_drop;
    logic [WFIFO_AW:0]        w_levelNext;
    logic [ADDR_W+DATA_W-1:0] w_head;

    assign w_wrPend    = (r_level != '0);
    assign w_hiWater   = (r_level >= c_HI);
    assign w_contended = w_wrPend && rdReq;
    assign w_head      = r_mem[r_rdPtr];

    // Below the high-water mark a contended cycle goes to whoever lost last time.
    always_comb begin
        w_grant = GNT_IDLE;
        if (w_wrPend && (w_hiWater || !rdReq)) begin
            w_grant = GNT_WRITE;
        end else if (w_wrPend) begin
            w_grant = r_lastWrite ? GNT_READ : GNT_WRITE;
        end else if (rdReq) begin
            w_grant = GNT_READ;
        end
    end

    assign w_pop  = (w_grant == GNT_WRITE);
    assign w_drop = wrPix && (r_level == c_FULL) && !w_pop;
    assign w_push = wrPix && !w_drop;
    assign rdAck  = rdReq && (w_grant == GNT_READ);

    always_comb begin
        w_levelNext = r_level;
        if (w_push && !w_pop) begin
            w_levelNext = r_level + 1'b1;
        end else if (!w_push && w_pop) begin
            w_levelNext = r_level - 1'b1;
        end
    end

    always_ff @(posedge pixClk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {wrAddr, wrData};
        end
    end

    always_ff @(posedge pixClk or negedge nReset) begin
        if (!nReset) begin
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
            r_level      <= '0;
            r_lastWrite  <= 1'b0;
            r_ramWe      <= 1'b0;
            r_ramRe      <= 1'b0;
            r_ramAddr    <= '0;
            r_ramWrData  <= '0;
            r_rdInFlight <= 1'b0;
            r_rdValid    <= 1'b0;
            r_rdData     <= '0;
            r_wrOverflow <= 1'b0;
        end else begin
            r_level <= w_levelNext;
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_contended) begin
                r_lastWrite <= w_pop;
            end

            r_ramWe <= w_pop;
            r_ramRe <= (w_grant == GNT_READ);
            if (w_pop) begin
                r_ramAddr   <= w_head[ADDR_W+DATA_W-1:DATA_W];
                r_ramWrData <= w_head[DATA_W-1:0];
            end else if (w_grant == GNT_READ) begin
                r_ramAddr <= rdAddr;
            end

            // RAM returns data the cycle after ramRe, so capture one cycle later.
            r_rdInFlight <= r_ramRe;
            r_rdValid    <= r_rdInFlight;
            if (r_rdInFlight) begin
                r_rdData <= ramRdData;
            end

            if (w_drop) begin
                r_wrOverflow <= 1'b1;
            end else if (frameStart) begin
                r_wrOverflow <= 1'b0;
            end
        end
    end

`ifdef FB_ARB_STATS_EN
    logic [15:0]       r_dropCount;
    logic [WFIFO_AW:0] r_maxLevel;

    // Events in the frameStart cycle belong to the new frame.
    always_ff @(posedge pixClk or negedge nReset) begin
        if (!nReset) begin
            r_dropCount <= '0;
            r_maxLevel  <= '0;
        end else if (frameStart) begin
            r_dropCount <= w_drop ? 16'd1 : 16'd0;
            r_maxLevel  <= w_levelNext;
        end else begin
            if (w_drop && (r_dropCount != 16'hFFFF)) begin
                r_dropCount <= r_dropCount + 16'd1;
            end
            if (w_levelNext > r_maxLevel) begin
                r_maxLevel <= w_levelNext;
            end
        end
    end

    assign dropCount = r_dropCount;
    assign maxLevel  = r_maxLevel;
`endif

    assign ramWe      = r_ramWe;
    assign ramRe      = r_ramRe;
    assign ramAddr    = r_ramAddr;
    assign ramWrData  = r_ramWrData;
    assign rdValid    = r_rdValid;
    assign rdData     = r_rdData;
    assign fifoLevel  = r_level;
    assign wrOverflow = r_wrOverflow;

endmodule
`default_nettype wire

// File: tb/tb_fb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_fb_port_arbiter
// Brief   : Self-checking bench for fb_port_arbiter; DUT A uses default
//           parameters, DUT B raises HI_WATER above depth so the FIFO can fill.
// Revision: 1.0
// ============================================================================
module tb_fb_port_arbiter;

    localparam int AW = 15;
    localparam int DW = 8;

    logic          pixClk = 1'b0;
    logic          nReset = 1'b0;
    logic          frameStart = 1'b0;
    logic          wrPix = 1'b0;
    logic [AW-1:0] wrAddr = '0;
    logic [DW-1:0] wrData = '0;
    logic          rdReq = 1'b0;
    logic [AW-1:0] rdAddr = '0;

    logic          a_rdAck, a_rdValid, a_ramWe, a_ramRe, a_wrOverflow;
    logic [DW-1:0] a_rdData, a_ramWrData, a_ramRdData;
    logic [AW-1:0] a_ramAddr;
    logic [2:0]    a_fifoLevel;
    logic          b_rdAck, b_rdValid, b_ramWe, b_ramRe, b_wrOverflow;
    logic [DW-1:0] b_rdData, b_ramWrData, b_ramRdData;
    logic [AW-1:0] b_ramAddr;
    logic [2:0]    b_fifoLevel;
`ifdef FB_ARB_STATS_EN
    logic [15:0]   a_dropCount, b_dropCount;
    logic [2:0]    a_maxLevel, b_maxLevel;
`endif

    int errs = 0;
    int checks = 0;

    always #5 pixClk = ~pixClk;

    fb_port_arbiter u_dut_a (
        .pixClk(pixClk), .nReset(nReset), .frameStart(frameStart),
        .wrPix(wrPix), .wrAddr(wrAddr), .wrData(wrData),
        .rdReq(rdReq), .rdAddr(rdAddr), .rdAck(a_rdAck),
        .rdValid(a_rdValid), .rdData(a_rdData),
        .ramAddr(a_ramAddr), .ramWrData(a_ramWrData), .ramWe(a_ramWe), .ramRe(a_ramRe),
        .ramRdData(a_ramRdData), .fifoLevel(a_fifoLevel),
`ifdef FB_ARB_STATS_EN
        .dropCount(a_dropCount), .maxLevel(a_maxLevel),
`endif
        .wrOverflow(a_wrOverflow)
    );

    fb_port_arbiter #(.HI_WATER(5)) u_dut_b (
        .pixClk(pixClk), .nReset(nReset), .frameStart(frameStart),
        .wrPix(wrPix), .wrAddr(wrAddr), .wrData(wrData),
        .rdReq(rdReq), .rdAddr(rdAddr), .rdAck(b_rdAck),
        .rdValid(b_rdValid), .rdData(b_rdData),
        .ramAddr(b_ramAddr), .ramWrData(b_ramWrData), .ramWe(b_ramWe), .ramRe(b_ramRe),
        .ramRdData(b_ramRdData), .fifoLevel(b_fifoLevel),
`ifdef FB_ARB_STATS_EN
        .dropCount(b_dropCount), .maxLevel(b_maxLevel),
`endif
        .wrOverflow(b_wrOverflow)
    );

    function automatic logic [7:0] rom(input logic [AW-1:0] a);
        return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h3C;
    endfunction

    // Synchronous-read RAM stand-ins: contents are a fixed function of address.
    always_ff @(posedge pixClk) begin
        if (a_ramRe) a_ramRdData <= rom(a_ramAddr);
        if (b_ramRe) b_ramRdData <= rom(b_ramAddr);
    end

    // ---------------- reference model of DUT A (HI_WATER=3, depth 4) --------
    logic [AW+DW-1:0] mq[$];
    bit               m_lastW = 1'b0;
    bit               m_acc = 1'b0;
    bit               p0v = 1'b0, p1v = 1'b0;
    logic [AW-1:0]    p0a = '0, p1a = '0;
    logic             exp_ramWe = 1'b0, exp_ramRe = 1'b0, exp_rdValid = 1'b0, exp_ovf = 1'b0;
    logic [AW-1:0]    exp_ramAddr = '0;
    logic [DW-1:0]    exp_ramWrData = '0, exp_rdData = '0;

    // 0 = idle, 1 = read, 2 = write
    function automatic int model_grant();
        int lvl = mq.size();
        if (lvl != 0 && (lvl >= 3 || !rdReq)) return 2;
        if (lvl != 0) return m_lastW ? 1 : 2;
        if (rdReq) return 1;
        return 0;
    endfunction

    task automatic model_step();
        int g;
        bit full, drop;
        logic [AW+DW-1:0] head;
        if (!nReset) begin
            mq.delete();
            m_lastW = 0; m_acc = 0; p0v = 0; p1v = 0;
            exp_ramWe = 0; exp_ramRe = 0; exp_rdValid = 0; exp_ovf = 0;
            return;
        end
        g = model_grant();
        full = (mq.size() == 4);
        m_acc = (g == 1);
        exp_rdValid = p1v;
        if (p1v) exp_rdData = rom(p1a);
        p1v = p0v; p1a = p0a;
        p0v = (g == 1); p0a = rdAddr;
        if (mq.size() != 0 && rdReq) m_lastW = (g == 2);
        exp_ramWe = (g == 2);
        exp_ramRe = (g == 1);
        if (g == 2) begin
            head = mq.pop_front();
            exp_ramAddr = head[AW+DW-1:DW];
            exp_ramWrData = head[DW-1:0];
        end else if (g == 1) begin
            exp_ramAddr = rdAddr;
        end
        drop = wrPix && full && (g != 2);
        if (wrPix && !drop) mq.push_back({wrAddr, wrData});
        if (drop) exp_ovf = 1;
        else if (frameStart) exp_ovf = 0;
    endtask

    task automatic tick();
        @(posedge pixClk);
        model_step();
        #1;
    endtask

    task automatic pulse_reset();
        nReset = 0; wrPix = 0; rdReq = 0; frameStart = 0;
        tick(); tick();
        nReset = 1;
    endtask

    // ---------------- tests -------------------------------------------------
    task automatic test_reset();
        pulse_reset();
        checks++; if ({a_ramWe, a_ramRe, a_rdValid, a_wrOverflow} !== 4'b0) begin
            errs++; $display("FAIL reset_flags got=%b exp=0000", {a_ramWe, a_ramRe, a_rdValid, a_wrOverflow}); end
        checks++; if (a_fifoLevel !== 3'd0 || a_ramAddr !== '0 || a_rdData !== '0) begin
            errs++; $display("FAIL reset_values level=%0d addr=%h rdData=%h exp 0", a_fifoLevel, a_ramAddr, a_rdData); end
        // Build traffic: level reaches 3 with a read issued at the last edge.
        rdReq = 1; rdAddr = 15'h0123; wrPix = 1;
        for (int i = 0; i < 5; i++) begin
            wrAddr = 15'(i); wrData = 8'(i + 1);
            tick();
        end
        checks++; if (a_fifoLevel !== 3'd3 || a_ramRe !== 1'b1) begin
            errs++; $display("FAIL midtraffic_setup level=%0d ramRe=%b exp 3/1", a_fifoLevel, a_ramRe); end
        nReset = 0;
        #1;
        checks++; if ({a_ramWe, a_ramRe, a_rdValid, a_wrOverflow} !== 4'b0 || a_fifoLevel !== 3'd0) begin
            errs++; $display("FAIL midtraffic_reset flags=%b level=%0d exp 0", {a_ramWe, a_ramRe, a_rdValid, a_wrOverflow}, a_fifoLevel); end
        wrPix = 0; rdReq = 0;
        tick(); tick();
        nReset = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if ({a_ramWe, a_ramRe, a_rdValid} !== 3'b0) begin
                errs++; $display("FAIL post_reset_stale cyc=%0d got=%b exp=000", i, {a_ramWe, a_ramRe, a_rdValid}); end
        end
    endtask

    task automatic test_write_only();
        rdReq = 0;
        for (int i = 0; i < 80; i++) begin
            wrPix = 1; wrAddr = 15'(i); wrData = 8'hA5;
            tick();
            wrPix = 0;
            checks++; if (a_fifoLevel !== 3'd1 || a_ramWe !== 1'b0) begin
                errs++; $display("FAIL wo_push i=%0d level=%0d ramWe=%b exp 1/0", i, a_fifoLevel, a_ramWe); end
            tick();
            checks++; if (a_ramWe !== 1'b1 || a_ramAddr !== 15'(i) || a_ramWrData !== 8'hA5 || a_fifoLevel !== 3'd0) begin
                errs++; $display("FAIL wo_write i=%0d we=%b addr=%0d data=%h level=%0d exp 1/%0d/a5/0",
                                 i, a_ramWe, a_ramAddr, a_ramWrData, a_fifoLevel, i); end
            tick();
            checks++; if (a_ramWe !== 1'b0 || a_ramRe !== 1'b0) begin
                errs++; $display("FAIL wo_idle i=%0d we=%b re=%b exp 0/0", i, a_ramWe, a_ramRe); end
            tick();
        end
    endtask

    task automatic test_read_only();
        for (int t = 0; t < 6; t++) begin
            rdReq = (t < 4);
            rdAddr = 15'(100 + t);
            #1;
            if (t < 4) begin
                checks++; if (a_rdAck !== 1'b1) begin
                    errs++; $display("FAIL ro_ack t=%0d got=%b exp=1", t, a_rdAck); end
            end
            tick();
            checks++; if (a_ramRe !== (t < 4) || (t < 4 && a_ramAddr !== 15'(100 + t))) begin
                errs++; $display("FAIL ro_issue t=%0d re=%b addr=%0d exp %0d/%0d", t, a_ramRe, a_ramAddr, t < 4, 100 + t); end
            checks++; if (a_rdValid !== (t >= 2) || (t >= 2 && a_rdData !== rom(15'(98 + t)))) begin
                errs++; $display("FAIL ro_data t=%0d valid=%b data=%h exp %0d/%h", t, a_rdValid, a_rdData, t >= 2, rom(15'(98 + t))); end
        end
        rdReq = 0;
        tick(); tick();
    endtask

    task automatic test_contention();
        logic [7:0] ackv;
        logic [7:0] wrv;
        int         lvl[8];
        ackv = 8'b1000_1010;   // bit c = expected rdAck in contended cycle c
        wrv  = 8'b0011_1111;
        lvl  = '{1, 2, 2, 3, 3, 3, 2, 2};
        pulse_reset();
        wrPix = 1; wrAddr = 15'h7000; wrData = 8'h11;
        tick();
        rdReq = 1; rdAddr = 15'd200;
        for (int c = 0; c < 8; c++) begin
            wrPix = wrv[c]; wrAddr = 15'(16'h7001 + c); wrData = 8'(8'h20 + c);
            #1;
            checks++; if (a_rdAck !== ackv[c]) begin
                errs++; $display("FAIL cont_ack c=%0d got=%b exp=%b", c, a_rdAck, ackv[c]); end
            tick();
            checks++; if (a_ramWe !== !ackv[c] || a_fifoLevel !== 3'(lvl[c])) begin
                errs++; $display("FAIL cont_grant c=%0d we=%b level=%0d exp %b/%0d", c, a_ramWe, a_fifoLevel, !ackv[c], lvl[c]); end
        end
        rdReq = 0; wrPix = 0;
        repeat (4) tick();
    endtask

    task automatic test_overflow();
        int lvl[11];
        lvl = '{1, 1, 2, 2, 3, 3, 4, 4, 4, 4, 4};
        pulse_reset();
        rdReq = 1; rdAddr = 15'd300; wrPix = 1;
        for (int e = 0; e < 11; e++) begin
            wrAddr = 15'(e); wrData = 8'(8'hC0 + e);
            tick();
            checks++; if (b_fifoLevel !== 3'(lvl[e]) || b_wrOverflow !== (e >= 8)) begin
                errs++; $display("FAIL ovf_step e=%0d level=%0d ovf=%b exp %0d/%b", e, b_fifoLevel, b_wrOverflow, lvl[e], e >= 8); end
            if (e == 7) begin
                checks++; if (b_ramWe !== 1'b1) begin
                    errs++; $display("FAIL full_pushpop we=%b exp=1", b_ramWe); end
            end
        end
`ifdef FB_ARB_STATS_EN
        checks++; if (b_dropCount !== 16'd2 || b_maxLevel !== 3'd4) begin
            errs++; $display("FAIL stats drops=%0d max=%0d exp 2/4", b_dropCount, b_maxLevel); end
`endif
        wrPix = 0; rdReq = 0;
        tick();
        frameStart = 1;
        tick();
        frameStart = 0;
        checks++; if (b_wrOverflow !== 1'b0 || b_fifoLevel !== 3'd2) begin
            errs++; $display("FAIL ovf_clear ovf=%b level=%0d exp 0/2", b_wrOverflow, b_fifoLevel); end
`ifdef FB_ARB_STATS_EN
        checks++; if (b_dropCount !== 16'd0) begin
            errs++; $display("FAIL stats_clear drops=%0d exp=0", b_dropCount); end
`endif
        repeat (4) tick();
    endtask

    task automatic test_random();
        bit ack_exp;
        for (int c = 0; c < 600; c++) begin
            wrPix = ($urandom_range(0, 99) < 45);
            wrAddr = 15'($urandom); wrData = 8'($urandom);
            frameStart = ($urandom_range(0, 99) < 3);
            if (!rdReq || m_acc) begin
                rdReq = ($urandom_range(0, 99) < 60);
                rdAddr = 15'($urandom);
            end
            #1;
            ack_exp = rdReq && (model_grant() == 1);
            checks++; if (a_rdAck !== ack_exp) begin
                errs++; $display("FAIL rnd_ack c=%0d got=%b exp=%b", c, a_rdAck, ack_exp); end
            tick();
            checks++; if (a_ramWe !== exp_ramWe || a_ramRe !== exp_ramRe) begin
                errs++; $display("FAIL rnd_issue c=%0d we/re=%b%b exp=%b%b", c, a_ramWe, a_ramRe, exp_ramWe, exp_ramRe); end
            if (exp_ramWe || exp_ramRe) begin
                checks++; if (a_ramAddr !== exp_ramAddr || (exp_ramWe && a_ramWrData !== exp_ramWrData)) begin
                    errs++; $display("FAIL rnd_ramaddr c=%0d addr=%h data=%h exp %h/%h", c, a_ramAddr, a_ramWrData, exp_ramAddr, exp_ramWrData); end
            end
            checks++; if (a_rdValid !== exp_rdValid || (exp_rdValid && a_rdData !== exp_rdData)) begin
                errs++; $display("FAIL rnd_rd c=%0d valid=%b data=%h exp %b/%h", c, a_rdValid, a_rdData, exp_rdValid, exp_rdData); end
            checks++; if (a_fifoLevel !== 3'(mq.size()) || a_wrOverflow !== exp_ovf) begin
                errs++; $display("FAIL rnd_fifo c=%0d level=%0d ovf=%b exp %0d/%b", c, a_fifoLevel, a_wrOverflow, mq.size(), exp_ovf); end
        end
        wrPix = 0; rdReq = 0; frameStart = 0;
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_write_only();
        test_read_only();
        test_contention();
        test_overflow();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout reached got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
